// File: rtl/pe_job_arbiter_if.sv
// Request, response and PE-side signals of the shared-PE job arbiter.
// slave = arbiter side, master = requesters/response sink/PE side.
interface pe_job_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FILT_SIZE  = 3,
  parameter int PSUM_WIDTH = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*FILT_SIZE*16-1:0] req_ifmap;
  logic [NUM_REQ*FILT_SIZE*16-1:0] req_filt;
  logic                            resp_valid;
  logic                            resp_ready;
  logic [ID_W-1:0]                 resp_id;
  logic [PSUM_WIDTH-1:0]           resp_psum;
  logic                            resp_err;
  logic                            busy;
  logic                            pe_start;
  logic                            pe_done;
  logic [FILT_SIZE*16-1:0]         pe_ifmap;
  logic [FILT_SIZE*16-1:0]         pe_filt;
  logic [PSUM_WIDTH-1:0]           pe_psum;

  modport slave (
    input  req_valid, req_ifmap, req_filt, resp_ready, pe_done, pe_psum,
    output req_ready, resp_valid, resp_id, resp_psum, resp_err, busy,
           pe_start, pe_ifmap, pe_filt
  );

  modport master (
    output req_valid, req_ifmap, req_filt, resp_ready, pe_done, pe_psum,
    input  req_ready, resp_valid, resp_id, resp_psum, resp_err, busy,
           pe_start, pe_ifmap, pe_filt
  );
endinterface

// File: rtl/pe_job_arbiter.sv
// Round-robin scheduler sharing one dot-product PE among NUM_REQ requesters,
// one job in flight, psum returned with requester id and watchdog error flag.
module pe_job_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FILT_SIZE  = 3,
  parameter int PSUM_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input logic              clk,
  input logic              rst,
  pe_job_arbiter_if.slave  bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OP_W = FILT_SIZE * 16;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  // Last WAIT_* cycle before expiry: RESP lands exactly TIMEOUT cycles after START.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, START, WAIT_CLR, WAIT_DONE, RESP} state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       job_id;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_vld;
  logic [OP_W-1:0]       sel_ifmap;
  logic [OP_W-1:0]       sel_filt;
  logic [OP_W-1:0]       ifmap_q;
  logic [OP_W-1:0]       filt_q;
  logic [WD_W-1:0]       wd_cnt;
  logic                  pe_start_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [PSUM_WIDTH-1:0] resp_psum_q;

  always_comb begin : rr_pick
    logic [ID_W:0] pos;
    grant_vld = 1'b0;
    grant_id  = '0;
    sel_ifmap = '0;
    sel_filt  = '0;
    pos       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(NUM_REQ)) pos = pos - (ID_W+1)'(NUM_REQ);
      if (!grant_vld && bus.req_valid[pos[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = pos[ID_W-1:0];
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_id == ID_W'(r)) begin
        sel_ifmap = bus.req_ifmap[r*OP_W +: OP_W];
        sel_filt  = bus.req_filt[r*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      job_id       <= '0;
      ifmap_q      <= '0;
      filt_q       <= '0;
      wd_cnt       <= '0;
      pe_start_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_psum_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ifmap_q    <= sel_ifmap;
            filt_q     <= sel_filt;
            job_id     <= grant_id;
            rr_ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            pe_start_q <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          pe_start_q <= 1'b0;
          wd_cnt     <= '0;
          state      <= WAIT_CLR;
        end
        WAIT_CLR, WAIT_DONE: begin
          // Done is only honoured after it has been seen low, so a PE still
          // showing the previous job's done cannot complete this one.
          if (state == WAIT_DONE && bus.pe_done) begin
            resp_psum_q  <= bus.pe_psum;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            resp_psum_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (state == WAIT_CLR && !bus.pe_done) state <= WAIT_DONE;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE && grant_vld) ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = job_id;
  assign bus.resp_psum  = resp_psum_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = (state != IDLE);
  assign bus.pe_start   = pe_start_q;
  assign bus.pe_ifmap   = ifmap_q;
  assign bus.pe_filt    = filt_q;
endmodule

// File: tb/tb_pe_job_arbiter.sv
// Bench for pe_job_arbiter: fp16 PE stub with programmable stale-done and hang modes,
// random operands and request masks checked against a round-robin reference model.
module tb_pe_job_arbiter;
  localparam int NR = 4;
  localparam int FS = 3;
  localparam int PW = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pe_job_arbiter_if #(.NUM_REQ(NR), .FILT_SIZE(FS), .PSUM_WIDTH(PW)) bus ();
  pe_job_arbiter #(.NUM_REQ(NR), .FILT_SIZE(FS), .PSUM_WIDTH(PW), .TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int opa [NR][FS];
  int opb [NR][FS];
  int rr_model = 0;
  int acc_cnt = 0, start_cnt = 0, onehot_bad = 0;
  int acc_id_q[$];

  // Small non-negative integers as fp16 (exact for the ranges used here).
  function automatic logic [15:0] i2h(input int v);
    int e;
    if (v <= 0) return 16'h0000;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {1'b0, 5'(e + 15), 10'(((v << 10) >> e) & 'h3FF)};
  endfunction

  function automatic int h2i(input logic [15:0] h);
    int ex;
    ex = int'(h[14:10]);
    if (ex == 0) return 0;
    if (ex >= 25) return (1024 + int'(h[9:0])) << (ex - 25);
    return (1024 + int'(h[9:0])) >> (25 - ex);
  endfunction

  function automatic logic [15:0] exp_psum(input int r);
    int s = 0;
    for (int k = 0; k < FS; k++) s += opa[r][k] * opb[r][k];
    return i2h(s);
  endfunction

  function automatic int pick(input logic [NR-1:0] m, input int p);
    for (int d = 0; d < NR; d++) if (m[(p + d) % NR]) return (p + d) % NR;
    return -1;
  endfunction

  // PE stub: result after FS+2 cycles; stub_hold keeps the old done high after start.
  int stub_hold = 0;
  bit stub_dead = 1'b0;
  int st_cnt, st_hold, st_sum;
  logic [15:0] st_res;
  always @(posedge clk) begin
    if (rst) begin
      bus.pe_done <= 1'b0;
      bus.pe_psum <= '0;
      st_cnt  <= 0;
      st_hold <= 0;
    end else if (bus.pe_start) begin
      st_sum = 0;
      for (int k = 0; k < FS; k++)
        st_sum += h2i(bus.pe_ifmap[k*16 +: 16]) * h2i(bus.pe_filt[k*16 +: 16]);
      st_res  <= i2h(st_sum);
      st_cnt  <= FS + 2 + stub_hold;
      st_hold <= stub_hold;
      if (stub_hold == 0) bus.pe_done <= 1'b0;
      if (stub_dead) bus.pe_psum <= 16'hBEEF;
    end else begin
      if (st_hold > 0) begin
        st_hold <= st_hold - 1;
        if (st_hold == 1) bus.pe_done <= 1'b0;
      end
      if (st_cnt > 0) begin
        st_cnt <= st_cnt - 1;
        if (st_cnt == 1 && !stub_dead) begin
          bus.pe_done <= 1'b1;
          bus.pe_psum <= st_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (!rst && |bus.req_ready) begin
      acc_cnt++;
      if (!$onehot(bus.req_ready)) onehot_bad++;
      for (int i = 0; i < NR; i++) if (bus.req_ready[i]) acc_id_q.push_back(i);
    end
    if (bus.pe_start) start_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input int fixed);
    for (int k = 0; k < FS; k++) begin
      opa[r][k] = (fixed < 0) ? int'($urandom_range(0, 4)) : fixed;
      opb[r][k] = (fixed < 0) ? int'($urandom_range(0, 4)) : fixed;
      bus.req_ifmap[(r*FS + k)*16 +: 16] = i2h(opa[r][k]);
      bus.req_filt[(r*FS + k)*16 +: 16]  = i2h(opb[r][k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) step();
    rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic wait_resp(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.resp_valid) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bus.req_valid  = '0;
    bus.req_ifmap  = '0;
    bus.req_filt   = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    n_vec++;
    if ({bus.resp_valid, bus.busy, bus.pe_start, bus.req_ready, bus.resp_err, bus.resp_id,
         bus.resp_psum, bus.pe_ifmap, bus.pe_filt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b rv=%b ifmap=%h psum=%h want all zero",
               bus.busy, bus.resp_valid, bus.pe_ifmap, bus.resp_psum);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_single();
    int t0, at;
    bit ok;
    step();
    set_ops(2, 1);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b0100;
    #1;
    t0 = cyc;
    n_vec++;
    if (bus.req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_accept: req_ready got %b want 0100", bus.req_ready);
    end
    rr_model = 3;
    step();
    bus.req_valid = '0;
    for (int k = 0; k < FS; k++) bus.req_ifmap[(2*FS + k)*16 +: 16] = 16'($urandom);
    n_vec++;
    if (bus.pe_start !== 1'b1) begin
      n_err++;
      $display("FAIL single_start: pe_start got %b want 1 in cycle 1", bus.pe_start);
    end
    wait_resp(40, ok, at);
    n_vec++;
    if (!ok || at - t0 != FS + 5) begin
      n_err++;
      $display("FAIL single_latency: ok=%b cycle got %0d want %0d", ok, at - t0, FS + 5);
    end
    n_vec++;
    if (bus.resp_id !== 2'd2 || bus.resp_psum !== 16'h4200 || bus.resp_err !== 1'b0) begin
      n_err++;
      $display("FAIL single_resp: id=%0d psum=%h err=%b want 2 4200 0",
               bus.resp_id, bus.resp_psum, bus.resp_err);
    end
    step();
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_drop: rv=%b busy=%b want 0 0", bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int a0, at, g, got;
    bit ok;
    do_reset();
    for (int r = 0; r < NR; r++) set_ops(r, -1);
    acc_id_q.delete();
    a0 = acc_cnt;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'hF;
    for (int j = 0; j < 5; j++) begin
      wait_resp(40, ok, at);
      g = pick(4'hF, rr_model);
      rr_model = (g + 1) % NR;
      got = (acc_id_q.size() > 0) ? acc_id_q.pop_front() : -1;
      n_vec++;
      if (!ok || got != g || int'(bus.resp_id) != g || bus.resp_psum !== exp_psum(g)) begin
        n_err++;
        $display("FAIL rr_job%0d: ok=%b grant=%0d id=%0d psum=%h want grant/id %0d psum %h",
                 j, ok, got, bus.resp_id, bus.resp_psum, g, exp_psum(g));
      end
      n_vec++;
      if (acc_cnt - a0 != j + 1) begin
        n_err++;
        $display("FAIL rr_pulses%0d: accepts got %0d want %0d", j, acc_cnt - a0, j + 1);
      end
      step();
      if (j == 4) bus.req_valid = '0;
    end
    repeat (4) step();
    n_vec++;
    if (acc_cnt - a0 != 5 || onehot_bad != 0) begin
      n_err++;
      $display("FAIL rr_total: accepts got %0d want 5, non-onehot %0d", acc_cnt - a0, onehot_bad);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] m, want;
    logic [15:0] ep;
    int g, at;
    bit ok;
    for (int it = 0; it < 16; it++) begin
      step();
      for (int r = 0; r < NR; r++) set_ops(r, -1);
      m = NR'($urandom_range(1, (1 << NR) - 1));
      bus.resp_ready = 1'b0;
      bus.req_valid  = m;
      #1;
      g = pick(m, rr_model);
      rr_model = (g + 1) % NR;
      ep = exp_psum(g);
      want = '0;
      want[g] = 1'b1;
      n_vec++;
      if (bus.req_ready !== want) begin
        n_err++;
        $display("FAIL rand_grant%0d: mask=%b req_ready got %b want %b", it, m, bus.req_ready, want);
      end
      step();
      bus.req_valid = '0;
      for (int r = 0; r < NR; r++) set_ops(r, -1);
      wait_resp(40, ok, at);
      repeat ($urandom_range(0, 3)) step();
      bus.resp_ready = 1'b1;
      n_vec++;
      if (!ok || int'(bus.resp_id) != g || bus.resp_psum !== ep || bus.resp_err !== 1'b0) begin
        n_err++;
        $display("FAIL rand_resp%0d: ok=%b id=%0d psum=%h err=%b want %0d %h 0",
                 it, ok, bus.resp_id, bus.resp_psum, bus.resp_err, g, ep);
      end
      step();
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int t0, at, vals[2];
    bit ok;
    vals[0] = 1;
    vals[1] = 2;
    stub_hold = 2;
    bus.resp_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      step();
      set_ops(1, vals[j]);
      bus.req_valid = 4'b0010;
      t0 = cyc;
      rr_model = 2;
      step();
      bus.req_valid = '0;
      wait_resp(60, ok, at);
      n_vec++;
      if (!ok || at - t0 < FS + 5 || bus.resp_psum !== i2h(3 * vals[j] * vals[j])) begin
        n_err++;
        $display("FAIL b2b_job%0d: ok=%b cycle=%0d psum=%h want >=%0d psum %h",
                 j, ok, at - t0, bus.resp_psum, FS + 5, i2h(3 * vals[j] * vals[j]));
      end
      step();
    end
    stub_hold = 0;
  endtask

  task automatic test_stall();
    logic [15:0] ep;
    int at;
    bit ok;
    step();
    set_ops(0, -1);
    set_ops(3, -1);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 4'b0001;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL stall_accept: req_ready got %b want 0001", bus.req_ready);
    end
    rr_model = 1;
    ep = exp_psum(0);
    step();
    bus.req_valid = 4'b1000;
    wait_resp(40, ok, at);
    for (int c = 0; c < 10; c++) begin
      step();
      n_vec++;
      if (!ok || bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_psum !== ep ||
          bus.resp_err !== 1'b0 || bus.req_ready !== '0 || bus.pe_start !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: rv=%b id=%0d psum=%h rr=%b st=%b want 1 0 %h 0000 0",
                 c, bus.resp_valid, bus.resp_id, bus.resp_psum, bus.req_ready, bus.pe_start, ep);
      end
    end
    bus.resp_ready = 1'b1;
    step();
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL stall_release: rv=%b busy=%b req_ready=%b want 0 0 1000",
               bus.resp_valid, bus.busy, bus.req_ready);
    end
    rr_model = 0;
    ep = exp_psum(3);
    step();
    bus.req_valid = '0;
    wait_resp(40, ok, at);
    n_vec++;
    if (!ok || bus.resp_id !== 2'd3 || bus.resp_psum !== ep) begin
      n_err++;
      $display("FAIL stall_next: ok=%b id=%0d psum=%h want 3 %h", ok, bus.resp_id, bus.resp_psum, ep);
    end
    step();
  endtask

  task automatic test_watchdog();
    int ts, at;
    bit ok;
    stub_dead = 1'b1;
    bus.resp_ready = 1'b1;
    step();
    set_ops(1, -1);
    bus.req_valid = 4'b0010;
    rr_model = 2;
    step();
    bus.req_valid = '0;
    ts = cyc;
    n_vec++;
    if (bus.pe_start !== 1'b1) begin
      n_err++;
      $display("FAIL wd_start: pe_start got %b want 1", bus.pe_start);
    end
    wait_resp(TO + 20, ok, at);
    n_vec++;
    if (!ok || at - ts != TO) begin
      n_err++;
      $display("FAIL wd_timing: ok=%b cycles after START got %0d want %0d", ok, at - ts, TO);
    end
    n_vec++;
    if (bus.resp_err !== 1'b1 || bus.resp_psum !== 16'h0000 || bus.resp_id !== 2'd1) begin
      n_err++;
      $display("FAIL wd_resp: err=%b psum=%h id=%0d want 1 0000 1",
               bus.resp_err, bus.resp_psum, bus.resp_id);
    end
    step();
    stub_dead = 1'b0;
  endtask

  task automatic test_reset_mid();
    int at, quiet;
    bit ok;
    bus.resp_ready = 1'b1;
    step();
    set_ops(2, -1);
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    repeat (2) step();
    rst = 1'b1;
    step();
    n_vec++;
    if ({bus.resp_valid, bus.busy, bus.pe_start, bus.req_ready, bus.resp_err, bus.resp_id,
         bus.resp_psum, bus.pe_ifmap, bus.pe_filt} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: busy=%b rv=%b ifmap=%h filt=%h want all zero",
               bus.busy, bus.resp_valid, bus.pe_ifmap, bus.pe_filt);
    end
    rst = 1'b0;
    rr_model = 0;
    quiet = 0;
    repeat (12) begin
      step();
      if (bus.resp_valid) quiet++;
    end
    n_vec++;
    if (quiet != 0) begin
      n_err++;
      $display("FAIL midrst_noresp: resp_valid cycles got %0d want 0", quiet);
    end
    for (int r = 0; r < NR; r++) set_ops(r, -1);
    bus.req_valid = 4'hF;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL midrst_ptr: req_ready got %b want 0001", bus.req_ready);
    end
    rr_model = 1;
    step();
    bus.req_valid = '0;
    wait_resp(40, ok, at);
    n_vec++;
    if (!ok || bus.resp_id !== 2'd0 || bus.resp_psum !== exp_psum(0)) begin
      n_err++;
      $display("FAIL midrst_job: ok=%b id=%0d psum=%h want 0 %h", ok, bus.resp_id, bus.resp_psum,
               exp_psum(0));
    end
    step();
    n_vec++;
    if (start_cnt != acc_cnt) begin
      n_err++;
      $display("FAIL start_per_accept: pe_start pulses %0d accepts %0d", start_cnt, acc_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_back_to_back();
    test_stall();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
